// File: rtl/acc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// acc_seq_ctrl
//   Sequencer for the add/load/display datapath. A start pulse in IDLE clears
//   the accumulator and programs an operand count. Operands are then accepted
//   over a dv/dr handshake, and each accepted operand is added into the
//   accumulator. The run ends with a one-cycle done pulse. The running sum
//   feeds the 7-segment decoder.
//
//   Optional feature: define ACC_SEQ_SAT_EN to saturate the accumulator at
//   all-ones on carry-out. When it is undefined, the sum wraps modulo 2**W.
//
// Ports:
//   c      in   clock, rising edge
//   rn     in   synchronous active-low reset
//   start  in   begin a run (only looked at in IDLE)
//   n      in   [CW] operand count, sampled with start (0 = empty run)
//   d      in   [W]  operand data
//   dv     in   operand valid
//   dr     out  operand ready (high only in ACC)
//   sum    out  [W] accumulator, registered
//   ovf    out  sticky carry-out flag for the current run
//   busy   out  high in ACC and DONE
//   done   out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module acc_seq_ctrl #(
  parameter int W  = 4,
  parameter int CW = 4
) (
  input  logic          c,
  input  logic          rn,
  input  logic          start,
  input  logic [CW-1:0] n,
  input  logic [W-1:0]  d,
  input  logic          dv,
  output logic          dr,
  output logic [W-1:0]  sum,
  output logic          ovf,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  SUM_ZERO = {W{1'b0}};
  localparam logic [W-1:0]  SUM_ONES = {W{1'b1}};

  state_t        state_r;
  logic [W-1:0]  sum_r;
  logic          ovf_r;
  logic [CW-1:0] cnt_r;
  logic          done_r;

  logic          xfer_s;
  logic [W:0]    add_s;
  logic [W-1:0]  sum_nxt_s;

  // Unsigned W+1-bit add; the top bit is the carry-out.
  function automatic logic [W:0] add_carry(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Transfer detect and next accumulator value (wrap or saturate).
  always_comb begin
    xfer_s    = (state_r == ST_ACC) && dv;
    add_s     = add_carry(sum_r, d);
    sum_nxt_s = add_s[W-1:0];
`ifdef ACC_SEQ_SAT_EN
    // Once the sum saturates, any further add also carries (or adds zero),
    // so the sum stays at all-ones for the rest of the run.
    if (add_s[W]) begin
      sum_nxt_s = SUM_ONES;
    end else begin
      sum_nxt_s = add_s[W-1:0];
    end
`endif
  end

  // Sequencer FSM with the accumulator, overflow flag, count and done pulse.
  always_ff @(posedge c) begin
    if (!rn) begin
      state_r <= ST_IDLE;
      sum_r   <= SUM_ZERO;
      ovf_r   <= 1'b0;
      cnt_r   <= CNT_ZERO;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sum_r <= SUM_ZERO;
            ovf_r <= 1'b0;
            if (n != CNT_ZERO) begin
              cnt_r   <= n;
              state_r <= ST_ACC;
            end else begin
              // Empty run: go straight to the completion pulse.
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACC: begin
          if (xfer_s) begin
            sum_r <= sum_nxt_s;
            ovf_r <= ovf_r | add_s[W];
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_ACC;
            end
          end else begin
            state_r <= ST_ACC;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // dr and busy are decoded from the state register only, so there is no
  // combinational path from any input to an output.
  assign dr   = (state_r == ST_ACC);
  assign busy = (state_r != ST_IDLE);
  assign sum  = sum_r;
  assign ovf  = ovf_r;
  assign done = done_r;

endmodule
